// File: rtl/dino_pkg.sv
// Shared types and helpers for the frame scheduler between the game CPU and VGA path.
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READY,
        BUSY,
        PENDING
    } fsync_state_t;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_sync_ctrl_debouncer.sv
// Two-flop synchroniser plus a stability counter for the jump button.
// rise is a one-cycle pulse registered together with dout going high.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Flip the stable level only after the input has disagreed with it long enough.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                rise   <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign dout = stable;

endmodule

// File: rtl/frame_sync_ctrl.sv
// Per-frame handshake between game CPU and display: vblank-gated coordinate
// commit, sticky debounced jump flag, and frame/skip/overrun statistics.
module frame_sync_ctrl
    import dino_pkg::*;
#(
    parameter int H_RES           = H_RES_DEF,
    parameter int V_RES           = V_RES_DEF,
    parameter int DEF_X           = 100,
    parameter int DEF_Y           = 400,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vblank_pulse,
    input  logic        jump_raw,
    input  logic [31:0] cpu_x,
    input  logic [31:0] cpu_y,
    input  logic        cpu_frame_ack,
    input  logic        cpu_frame_done,
    output logic        screen_end,
    output logic        button_press,
    output logic [9:0]  disp_x,
    output logic [9:0]  disp_y,
    output logic [15:0] frame_cnt,
    output logic [7:0]  skip_cnt,
    output logic [7:0]  overrun_cnt
);

    localparam logic [9:0] X_MAX = 10'(H_RES - 1);
    localparam logic [9:0] Y_MAX = 10'(V_RES - 1);

    fsync_state_t state, state_next;
    logic commit, skip_inc, ovr_inc, ack_ok;
    logic jump_level, jump_rise, jump_set;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_jump (
        .clk   (clk),
        .reset (reset),
        .din   (jump_raw),
        .dout  (jump_level),
        .rise  (jump_rise)
    );

    // rise is only ever registered alongside the new high level
    assign jump_set = jump_rise & jump_level;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and per-cycle events; ack beats vblank in READY, done+vblank commits at once.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        skip_inc   = 1'b0;
        ovr_inc    = 1'b0;
        ack_ok     = 1'b0;
        case (state)
            IDLE: if (vblank_pulse) state_next = READY;
            READY: begin
                if (cpu_frame_ack) begin
                    ack_ok     = 1'b1;
                    state_next = BUSY;
                end else if (vblank_pulse) begin
                    skip_inc = 1'b1;
                end
            end
            BUSY: begin
                if (cpu_frame_done) begin
                    if (vblank_pulse) begin
                        commit     = 1'b1;
                        state_next = READY;
                    end else begin
                        state_next = PENDING;
                    end
                end else if (vblank_pulse) begin
                    ovr_inc = 1'b1;
                end
            end
            PENDING: begin
                if (vblank_pulse) begin
                    commit     = 1'b1;
                    state_next = READY;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs: shadow coordinates, counters and the sticky jump flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            screen_end   <= 1'b0;
            button_press <= 1'b0;
            disp_x       <= 10'(DEF_X);
            disp_y       <= 10'(DEF_Y);
            frame_cnt    <= '0;
            skip_cnt     <= '0;
            overrun_cnt  <= '0;
        end else begin
            screen_end <= (state_next == READY);
            if (commit) begin
                disp_x    <= (cpu_x >= 32'(H_RES)) ? X_MAX : cpu_x[9:0];
                disp_y    <= (cpu_y >= 32'(V_RES)) ? Y_MAX : cpu_y[9:0];
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (skip_inc) skip_cnt    <= sat_inc8(skip_cnt);
            if (ovr_inc)  overrun_cnt <= sat_inc8(overrun_cnt);
            if (jump_set)    button_press <= 1'b1;
            else if (ack_ok) button_press <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Self-checking bench for frame_sync_ctrl: directed vector table, jump/reset
// sequences, saturation, then randomized traffic against a reference model.
module tb_frame_sync_ctrl;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        vblank_pulse = 1'b0;
    logic        jump_raw = 1'b0;
    logic [31:0] cpu_x = '0;
    logic [31:0] cpu_y = '0;
    logic        cpu_frame_ack = 1'b0;
    logic        cpu_frame_done = 1'b0;
    logic        screen_end, button_press;
    logic [9:0]  disp_x, disp_y;
    logic [15:0] frame_cnt;
    logic [7:0]  skip_cnt, overrun_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    frame_sync_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk            (clk),
        .reset          (reset),
        .vblank_pulse   (vblank_pulse),
        .jump_raw       (jump_raw),
        .cpu_x          (cpu_x),
        .cpu_y          (cpu_y),
        .cpu_frame_ack  (cpu_frame_ack),
        .cpu_frame_done (cpu_frame_done),
        .screen_end     (screen_end),
        .button_press   (button_press),
        .disp_x         (disp_x),
        .disp_y         (disp_y),
        .frame_cnt      (frame_cnt),
        .skip_cnt       (skip_cnt),
        .overrun_cnt    (overrun_cnt)
    );

    typedef struct {
        logic        vb, ack, done;
        logic [31:0] x, y;
        logic        se;
        logic [9:0]  dx, dy;
        logic [15:0] fc;
        logic [7:0]  sc, oc;
    } vec_t;

    vec_t vecs[17];

    // reference model: described as ownership of the frame, not as the DUT's states
    bit armed, cpu_owns, coords_final, m_btn;
    int m_dx, m_dy, m_fc, m_sc, m_oc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vb, input logic ack, input logic done,
                         input logic [31:0] x, input logic [31:0] y);
        vblank_pulse   = vb;
        cpu_frame_ack  = ack;
        cpu_frame_done = done;
        cpu_x          = x;
        cpu_y          = y;
    endtask

    function automatic logic [53:0] outs;
        return {button_press, screen_end, disp_x, disp_y, frame_cnt, skip_cnt, overrun_cnt};
    endfunction

    task automatic model_reset;
        armed = 0; cpu_owns = 0; coords_final = 0; m_btn = 0;
        m_dx = 100; m_dy = 400; m_fc = 0; m_sc = 0; m_oc = 0;
    endtask

    task automatic model_commit;
        m_dx = (cpu_x >= 32'd640) ? 639 : int'(cpu_x);
        m_dy = (cpu_y >= 32'd480) ? 479 : int'(cpu_y);
        m_fc = (m_fc + 1) % 65536;
        cpu_owns = 0;
        coords_final = 0;
    endtask

    task automatic model_step;
        if (!armed) begin
            if (vblank_pulse) armed = 1;
        end else if (!cpu_owns) begin
            if (cpu_frame_ack) begin
                cpu_owns = 1; coords_final = 0; m_btn = 0;
            end else if (vblank_pulse) begin
                m_sc = (m_sc < 255) ? m_sc + 1 : 255;
            end
        end else if (!coords_final) begin
            if (cpu_frame_done) begin
                if (vblank_pulse) model_commit();
                else coords_final = 1;
            end else if (vblank_pulse) begin
                m_oc = (m_oc < 255) ? m_oc + 1 : 255;
            end
        end else if (vblank_pulse) begin
            model_commit();
        end
    endtask

    function automatic logic [53:0] model_outs;
        return {m_btn, armed && !cpu_owns, 10'(m_dx), 10'(m_dy), 16'(m_fc), 8'(m_sc), 8'(m_oc)};
    endfunction

    function automatic logic [31:0] rand_coord;
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 639);
            1: return $urandom_range(630, 650);
            2: return $urandom;
            default: return 32'hFFFF_FFFF - $urandom_range(0, 3);
        endcase
    endfunction

    initial begin
        //          vb ack dn  x            y             se  dx   dy   fc sc oc
        vecs[0]  = '{1, 0, 0, 0,           0,            1, 100, 400, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0,           0,            1, 100, 400, 0, 1, 0};
        vecs[2]  = '{0, 1, 0, 0,           0,            0, 100, 400, 0, 1, 0};
        vecs[3]  = '{1, 0, 0, 0,           0,            0, 100, 400, 0, 1, 1};
        vecs[4]  = '{1, 0, 0, 0,           0,            0, 100, 400, 0, 1, 2};
        vecs[5]  = '{0, 0, 1, 320,         200,          0, 100, 400, 0, 1, 2};
        vecs[6]  = '{1, 0, 0, 320,         200,          1, 320, 200, 1, 1, 2};
        vecs[7]  = '{1, 1, 0, 0,           0,            0, 320, 200, 1, 1, 2};
        vecs[8]  = '{1, 0, 1, 700,         32'hFFFFFFFF, 1, 639, 479, 2, 1, 2};
        vecs[9]  = '{0, 0, 1, 7,           7,            1, 639, 479, 2, 1, 2};
        vecs[10] = '{0, 1, 0, 0,           0,            0, 639, 479, 2, 1, 2};
        vecs[11] = '{0, 1, 0, 0,           0,            0, 639, 479, 2, 1, 2};
        vecs[12] = '{0, 0, 1, 639,         479,          0, 639, 479, 2, 1, 2};
        vecs[13] = '{0, 1, 0, 0,           0,            0, 639, 479, 2, 1, 2};
        vecs[14] = '{1, 0, 0, 640,         0,            1, 639, 0,   3, 1, 2};
        vecs[15] = '{0, 1, 0, 0,           0,            0, 639, 0,   3, 1, 2};
        vecs[16] = '{1, 0, 1, 639,         479,          1, 639, 479, 4, 1, 2};

        // reset values
        #22;
        check("reset_outs", outs(), {1'b0, 1'b0, 10'd100, 10'd400, 16'd0, 8'd0, 8'd0});
        reset = 1'b1;

        // directed table
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].vb, vecs[i].ack, vecs[i].done, vecs[i].x, vecs[i].y);
            tick();
            check($sformatf("vec%0d", i), {10'd0, screen_end, disp_x, disp_y, frame_cnt, skip_cnt, overrun_cnt},
                  {10'd0, vecs[i].se, vecs[i].dx, vecs[i].dy, vecs[i].fc, vecs[i].sc, vecs[i].oc});
        end
        drive(0, 0, 0, 0, 0);

        // short glitch must not set the flag
        jump_raw = 1'b1;
        repeat (3) tick();
        jump_raw = 1'b0;
        repeat (8) tick();
        check("jump_short", button_press, 0);

        // held press: flag rises exactly 2+DB+1 cycles after the input
        jump_raw = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 6) check("jump_c6", button_press, 0);
            if (c == 7) check("jump_c7", button_press, 1);
        end
        jump_raw = 1'b0;
        cpu_frame_ack = 1'b1;
        tick();
        cpu_frame_ack = 1'b0;
        check("ack_clears", {screen_end, button_press}, 2'b00);

        // commit then a new rise coinciding with the clearing ack
        drive(1, 0, 1, 50, 60);
        tick();
        drive(0, 0, 0, 0, 0);
        check("commit5", {screen_end, disp_x, disp_y, frame_cnt}, {1'b1, 10'd50, 10'd60, 16'd5});
        repeat (12) tick();
        jump_raw = 1'b1;
        repeat (6) tick();
        check("pre_setwin", button_press, 0);
        cpu_frame_ack = 1'b1;
        tick();
        cpu_frame_ack = 1'b0;
        jump_raw = 1'b0;
        check("set_wins", {screen_end, button_press}, 2'b01);

        // reset while PENDING aborts without commit, asynchronously
        drive(0, 0, 1, 300, 300);
        tick();
        drive(0, 0, 0, 0, 0);
        check("pending", {screen_end, frame_cnt}, {1'b0, 16'd5});
        #2 reset = 1'b0;
        #1 check("async_reset", outs(), {1'b0, 1'b0, 10'd100, 10'd400, 16'd0, 8'd0, 8'd0});
        #1 reset = 1'b1;

        // saturation of both event counters
        drive(1, 0, 0, 0, 0);
        repeat (261) tick();
        check("skip_sat", {skip_cnt, screen_end}, {8'd255, 1'b1});
        drive(0, 1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0);
        repeat (260) tick();
        drive(0, 0, 0, 0, 0);
        check("ovr_sat", {overrun_cnt, skip_cnt, screen_end}, {8'd255, 8'd255, 1'b0});

        // randomized traffic against the model
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0), rand_coord(), rand_coord());
            tick();
            model_step();
            check($sformatf("rand%0d", n), outs(), model_outs());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
